// File: rtl/uart_debug_bridge.sv
// Host command responder: decodes UART command bytes, drives the register-file debug port
// and the CPU halt line, and returns one response byte per valid command.
module uart_debug_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter logic [7:0]  PING_BYTE      = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_ready,
    input  logic [7:0] i_rx_data,
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_dbg_we,
    output logic [1:0] o_dbg_addr,
    output logic [7:0] o_dbg_wdata,
    input  logic [7:0] i_dbg_rdata,
    output logic       o_cpu_halt,
    output logic       o_overrun
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_PING  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_DATA,
        S_WRITE,
        S_READ,
        S_RESP,
        S_RESP_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic       r_tx_start,  w_tx_start_nxt;
    logic [7:0] r_tx_data,   w_tx_data_nxt;
    logic       r_dbg_we,    w_dbg_we_nxt;
    logic [1:0] r_dbg_addr,  w_dbg_addr_nxt;
    logic [7:0] r_dbg_wdata, w_dbg_wdata_nxt;
    logic       r_cpu_halt,  w_cpu_halt_nxt;
    logic       r_overrun,   w_overrun_nxt;

    logic [1:0] w_op;
    logic [1:0] w_arg;
    logic       w_field_ok;
    logic       w_timeout;
    logic       w_accepting;

    assign w_op        = i_rx_data[7:6];
    assign w_arg       = i_rx_data[1:0];
    assign w_field_ok  = (i_rx_data[5:2] == 4'b0000);
    assign w_timeout   = (r_cnt == CNT_LAST);
    assign w_accepting = (r_state == S_IDLE) || (r_state == S_GET_DATA);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a data byte arriving on the timeout cycle still wins
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_ready) begin
                    if (!w_field_ok) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        case (w_op)
                            OP_WRITE: w_state_nxt = S_GET_DATA;
                            OP_READ:  w_state_nxt = S_READ;
                            default:  w_state_nxt = S_RESP;
                        endcase
                    end
                end
            end
            S_GET_DATA: begin
                if (i_rx_ready) begin
                    w_state_nxt = S_WRITE;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE:     w_state_nxt = S_RESP;
            S_READ:      w_state_nxt = S_RESP;
            S_RESP: begin
                if (!i_tx_busy) begin
                    w_state_nxt = S_RESP_WAIT;
                end
            end
            S_RESP_WAIT: begin
                if (i_tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the timeout counter
    always_comb begin
        w_tx_start_nxt  = 1'b0;
        w_dbg_we_nxt    = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_dbg_addr_nxt  = r_dbg_addr;
        w_dbg_wdata_nxt = r_dbg_wdata;
        w_cpu_halt_nxt  = r_cpu_halt;
        w_cnt_nxt       = r_cnt;
        w_overrun_nxt   = r_overrun | (i_rx_ready & ~w_accepting);
        case (r_state)
            S_IDLE: begin
                if (i_rx_ready) begin
                    if (!w_field_ok) begin
                        w_tx_data_nxt = NAK_BYTE;
                    end else begin
                        case (w_op)
                            OP_PING: w_tx_data_nxt = PING_BYTE;
                            OP_WRITE: begin
                                w_dbg_addr_nxt = w_arg;
                                w_cnt_nxt      = '0;
                            end
                            OP_READ: w_dbg_addr_nxt = w_arg;
                            default: begin
                                w_cpu_halt_nxt = w_arg[0];
                                w_tx_data_nxt  = ACK_BYTE;
                            end
                        endcase
                    end
                end
            end
            S_GET_DATA: begin
                if (i_rx_ready) begin
                    w_dbg_wdata_nxt = i_rx_data;
                    w_dbg_we_nxt    = 1'b1;
                end else if (!w_timeout) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WRITE: w_tx_data_nxt = ACK_BYTE;
            S_READ:  w_tx_data_nxt = i_dbg_rdata;
            S_RESP: begin
                if (!i_tx_busy) begin
                    w_tx_start_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_dbg_we    <= 1'b0;
            r_dbg_addr  <= 2'b00;
            r_dbg_wdata <= 8'h00;
            r_cpu_halt  <= 1'b0;
            r_overrun   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_tx_start  <= w_tx_start_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_dbg_we    <= w_dbg_we_nxt;
            r_dbg_addr  <= w_dbg_addr_nxt;
            r_dbg_wdata <= w_dbg_wdata_nxt;
            r_cpu_halt  <= w_cpu_halt_nxt;
            r_overrun   <= w_overrun_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;
    assign o_dbg_we    = r_dbg_we;
    assign o_dbg_addr  = r_dbg_addr;
    assign o_dbg_wdata = r_dbg_wdata;
    assign o_cpu_halt  = r_cpu_halt;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_debug_bridge.sv
// Bench for uart_debug_bridge: command-level model with expected response/write queues,
// a uart_tx busy model and a 4-entry register file.
module tb_uart_debug_bridge;

    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       dbg_we;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_wdata;
    logic [7:0] dbg_rdata;
    logic       cpu_halt;
    logic       overrun;

    uart_debug_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_ready  (rx_ready),
        .i_rx_data   (rx_data),
        .i_tx_busy   (tx_busy),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .o_dbg_we    (dbg_we),
        .o_dbg_addr  (dbg_addr),
        .o_dbg_wdata (dbg_wdata),
        .i_dbg_rdata (dbg_rdata),
        .o_cpu_halt  (cpu_halt),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Environment: uart_tx busy for a random few cycles after each start, plus a forced-busy override
    int   busy_cnt;
    logic force_busy = 1'b0;
    assign tx_busy = force_busy | (busy_cnt != 0);
    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 0;
        else if (tx_start && busy_cnt == 0) busy_cnt <= int'($urandom_range(1, 5));
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    logic [7:0] rf [4];
    assign dbg_rdata = rf[dbg_addr];
    always @(posedge clk) if (dbg_we) rf[dbg_addr] <= dbg_wdata;

    // Command-level reference model
    logic [7:0] rq [$];
    logic [9:0] wq [$];
    logic [7:0] model_mem [4];
    logic       model_halt = 1'b0;
    logic       model_ovr  = 1'b0;

    task automatic fail_msg(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) fail_msg(name, act, exp);
        else n_vec++;
    endtask

    // Per-cycle compare of every transmitted byte and every register-file write
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                if (rq.size() == 0) fail_msg("unexpected_tx_start", {24'h0, tx_data}, 32'h0);
                else begin
                    check("tx_data", {24'h0, tx_data}, {24'h0, rq.pop_front()});
                    check("halt_at_resp", {31'h0, cpu_halt}, {31'h0, model_halt});
                    check("overrun_at_resp", {31'h0, overrun}, {31'h0, model_ovr});
                end
            end
            if (dbg_we) begin
                if (wq.size() == 0) fail_msg("unexpected_dbg_we", {22'h0, dbg_addr, dbg_wdata}, 32'h0);
                else check("dbg_write", {22'h0, dbg_addr, dbg_wdata}, {22'h0, wq.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (rq.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (rq.size() != 0) begin
            fail_msg("response_timeout", rq.size(), 0);
            rq.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"},  {31'h0, tx_start}, 32'h0);
        check({tag, "_tx_data"},   {24'h0, tx_data}, 32'h0);
        check({tag, "_dbg_we"},    {31'h0, dbg_we}, 32'h0);
        check({tag, "_dbg_addr"},  {30'h0, dbg_addr}, 32'h0);
        check({tag, "_dbg_wdata"}, {24'h0, dbg_wdata}, 32'h0);
        check({tag, "_cpu_halt"},  {31'h0, cpu_halt}, 32'h0);
        check({tag, "_overrun"},   {31'h0, overrun}, 32'h0);
    endtask

    // Model of one well-formed command; gap = idle cycles between command and data byte
    task automatic model_cmd(input logic [7:0] cmd, input logic [7:0] data, input int gap);
        logic [3:0] field;
        logic [1:0] op;
        logic [1:0] arg;
        field = cmd[5:2];
        op    = cmd[7:6];
        arg   = cmd[1:0];
        send_byte(cmd);
        if (field != 4'h0) rq.push_back(8'h15);
        else if (op == 2'b00) rq.push_back(8'hA5);
        else if (op == 2'b10) rq.push_back(model_mem[arg]);
        else if (op == 2'b11) begin
            model_halt = arg[0];
            rq.push_back(8'h06);
        end else begin
            // Data strobe must land within TMO cycles of the command strobe
            if (gap + 2 <= int'(TMO)) begin
                wq.push_back({arg, data});
                model_mem[arg] = data;
                rq.push_back(8'h06);
            end
            repeat (gap) @(posedge clk);
            send_byte(data);
        end
        wait_idle();
    endtask

    initial begin
        logic [7:0] c;
        int r;
        for (int i = 0; i < 4; i++) begin
            rf[i] = 8'h00;
            model_mem[i] = 8'h00;
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: PING
        send_byte(8'h00);
        rq.push_back(8'hA5);
        wait_idle();
        check("ping_overrun", {31'h0, overrun}, 32'h0);

        // 2: WRITE addr 2
        send_byte(8'h42);
        send_byte(8'h3C);
        wq.push_back({2'd2, 8'h3C});
        rq.push_back(8'h06);
        model_mem[2] = 8'h3C;
        wait_idle();
        check("write_addr", {30'h0, dbg_addr}, 32'h2);
        check("write_wdata", {24'h0, dbg_wdata}, 32'h3C);
        check("rf2", {24'h0, rf[2]}, 32'h3C);

        // 3: READ addr 1
        rf[1] = 8'h7E;
        model_mem[1] = 8'h7E;
        send_byte(8'h81);
        rq.push_back(8'h7E);
        wait_idle();
        check("read_addr", {30'h0, dbg_addr}, 32'h1);

        // 4: WRITE timeout, then PING
        send_byte(8'h41);
        repeat (TMO + 4) @(posedge clk);
        send_byte(8'h00);
        rq.push_back(8'hA5);
        wait_idle();

        // 4b: data on the last allowed cycle is written; one cycle later it is a fresh (malformed) command
        send_byte(8'h43);
        repeat (TMO - 2) @(posedge clk);
        send_byte(8'h5A);
        wq.push_back({2'd3, 8'h5A});
        rq.push_back(8'h06);
        model_mem[3] = 8'h5A;
        wait_idle();
        send_byte(8'h40);
        repeat (TMO - 1) @(posedge clk);
        send_byte(8'h3C);
        rq.push_back(8'h15);
        wait_idle();
        check("rf0_untouched", {24'h0, rf[0]}, 32'h0);

        // 5: HALT on/off and malformed
        send_byte(8'hC1);
        rq.push_back(8'h06);
        model_halt = 1'b1;
        wait_idle();
        check("halt_on", {31'h0, cpu_halt}, 32'h1);
        send_byte(8'hC0);
        rq.push_back(8'h06);
        model_halt = 1'b0;
        wait_idle();
        check("halt_off", {31'h0, cpu_halt}, 32'h0);
        send_byte(8'h24);
        rq.push_back(8'h15);
        wait_idle();
        check("halt_after_nak", {31'h0, cpu_halt}, 32'h0);

        // 6: overrun while waiting on a busy transmitter
        send_byte(8'hC1);
        rq.push_back(8'h06);
        model_halt = 1'b1;
        wait_idle();
        force_busy = 1'b1;
        send_byte(8'h00);
        rq.push_back(8'hA5);
        send_byte(8'h00);
        model_ovr = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("overrun_set", {31'h0, overrun}, 32'h1);
        check("no_start_while_busy", rq.size(), 1);
        force_busy = 1'b0;
        wait_idle();

        // 6b: reset while a response is pending
        force_busy = 1'b1;
        send_byte(8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        rq.delete();
        model_halt = 1'b0;
        model_ovr  = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        force_busy = 1'b0;
        repeat (20) @(posedge clk);

        // Randomized command stream
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            c = 8'($urandom);
            if (r <= 1)      c = {2'b00, 4'h0, c[1:0]};
            else if (r <= 4) c = {2'b01, 4'h0, c[1:0]};
            else if (r <= 6) c = {2'b10, 4'h0, c[1:0]};
            else if (r == 7) c = {2'b11, 4'h0, c[1:0]};
            else if (c[5:2] == 4'h0) c[2] = 1'b1;
            model_cmd(c, 8'($urandom), int'($urandom_range(0, 10)));
        end

        check("resp_queue_empty", rq.size(), 0);
        check("write_queue_empty", wq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
